// File: rtl/fx3_result_collector_if.sv
// Upstream word handshake and host-side stream grouped in one bundle.
// master = the collector, slave = sequencer/host environment around it.
interface fx3_result_collector_if #(
    parameter int DATA_W = 23
);
    logic              intr;
    logic [DATA_W-1:0] data_in;
    logic              ack;
    logic              stop;
    logic [3:0]        specreg;
    logic [DATA_W:0]   host_data;
    logic              host_valid;
    logic              host_ready;

    // Host stream: a word moves on every rising clk edge where host_valid and
    // host_ready are both 1; while host_valid=1 and host_ready=0 the word is held.
    modport master (
        input  intr, data_in, stop, specreg, host_ready,
        output ack, host_data, host_valid
    );

    modport slave (
        output intr, data_in, stop, specreg, host_ready,
        input  ack, host_data, host_valid
    );
endinterface

// File: rtl/fx3_result_collector.sv
// Captures sequencer words into a FIFO, streams them to the FX3 host and
// appends a tagged pass/fail summary word once the sequence stops.
module fx3_result_collector #(
    parameter int DATA_W  = 23,
    parameter int FIFO_AW = 4
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 clr,
    fx3_result_collector_if.master bus,
    output logic [15:0]          word_cnt,
    output logic                 stalled,
    output logic                 done,
    output logic [1:0]           state_dbg
);
    localparam int HW    = DATA_W + 1;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW+1:0] DEPTH_V = (FIFO_AW + 2)'(DEPTH);

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_ACK  = 2'd1,
        C_WAIT = 2'd2,
        C_END  = 2'd3
    } cap_state_t;

    cap_state_t state_q, state_d;

    logic [HW-1:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [FIFO_AW:0]   fcount;
    logic [HW-1:0]      out_data;
    logic               out_valid;
    logic               ack_q;

    logic               push, pop, data_cap, stall_c, host_fire, full, room;
    logic [HW-1:0]      push_data;
    logic [FIFO_AW+1:0] occupancy;

    // The output register counts towards capacity, so the whole path holds DEPTH words.
    assign occupancy = {1'b0, fcount} + {{(FIFO_AW + 1){1'b0}}, out_valid};
    assign full      = (occupancy >= DEPTH_V);
    assign host_fire = out_valid & bus.host_ready;
    // A word leaving to the host frees a slot in the same cycle.
    assign room      = ~full | host_fire;
    assign pop       = (fcount != '0) & (~out_valid | bus.host_ready);

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_data = '0;
        data_cap  = 1'b0;
        stall_c   = 1'b0;
        case (state_q)
            C_IDLE: begin
                if (bus.intr) begin
                    if (room) begin
                        push      = 1'b1;
                        push_data = {1'b0, bus.data_in};
                        data_cap  = 1'b1;
                        state_d   = C_ACK;
                    end else begin
                        stall_c = 1'b1;
                    end
                end else if (bus.stop && room) begin
                    push      = 1'b1;
                    push_data = {1'b1, {(DATA_W - 4){1'b0}}, bus.specreg};
                    state_d   = C_END;
                end
            end
            C_ACK:   state_d = C_WAIT;
            C_WAIT:  if (!bus.intr) state_d = C_IDLE;
            C_END:   state_d = C_END;
            default: state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q   <= C_IDLE;
            ack_q     <= 1'b0;
            word_cnt  <= '0;
            wptr      <= '0;
            rptr      <= '0;
            fcount    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else if (clr) begin
            state_q   <= C_IDLE;
            ack_q     <= 1'b0;
            word_cnt  <= '0;
            wptr      <= '0;
            rptr      <= '0;
            fcount    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= data_cap;
            if (data_cap && (word_cnt != 16'hFFFF)) begin
                word_cnt <= word_cnt + 16'd1;
            end
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr      <= rptr + 1'b1;
                out_data  <= mem[rptr];
                out_valid <= 1'b1;
            end else if (host_fire) begin
                out_valid <= 1'b0;
            end
            case ({push, pop})
                2'b10:   fcount <= fcount + 1'b1;
                2'b01:   fcount <= fcount - 1'b1;
                default: fcount <= fcount;
            endcase
            if (host_fire && out_data[HW-1]) begin
                done <= 1'b1;
            end
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.host_data  = out_data;
    assign bus.host_valid = out_valid;
    assign stalled        = stall_c & ~clr;
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_fx3_result_collector.sv
// Directed + randomized bench for fx3_result_collector with a queue-based
// model of the words the host must receive, in order.
module tb_fx3_result_collector;
    localparam int DATA_W = 23;
    localparam int HW     = DATA_W + 1;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic arst = 1'b0;
    logic clr  = 1'b0;
    always #5 clk = ~clk;

    fx3_result_collector_if #(.DATA_W(DATA_W)) bus ();
    logic [15:0] word_cnt;
    logic        stalled;
    logic        done;
    logic [1:0]  state_dbg;

    fx3_result_collector #(.DATA_W(DATA_W), .FIFO_AW(4)) dut (
        .clk       (clk),
        .arst      (arst),
        .clr       (clr),
        .bus       (bus.master),
        .word_cnt  (word_cnt),
        .stalled   (stalled),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int            n_assert = 0;
    int            n_fail   = 0;
    logic [HW-1:0] exp_q[$];
    int            m_cnt    = 0;
    logic          m_done   = 1'b0;
    int            ack_seen = 0;
    int            ready_mode = 1;

    logic          s_ack, s_valid, s_stalled, s_done;
    logic [HW-1:0] s_data;
    logic [15:0]   s_word_cnt;
    logic          prev_valid = 1'b0, prev_ready = 1'b0, prev_ack = 1'b0, prev_block = 1'b1;
    logic [HW-1:0] prev_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: sample at negedge, run host-side checks, update model,
    // then move inputs 1 time unit after the rising edge.
    task automatic tick();
        logic [HW-1:0] e;
        logic          fire;
        logic          set_done;
        set_done = 1'b0;
        @(negedge clk);
        s_ack      = bus.ack;
        s_valid    = bus.host_valid;
        s_data     = bus.host_data;
        s_stalled  = stalled;
        s_done     = done;
        s_word_cnt = word_cnt;
        fire       = s_valid & bus.host_ready;
        if (arst) begin
            if (prev_valid && !prev_ready && !prev_block) begin
                check("hold_valid", 32'(s_valid), 32'd1);
                check("hold_data", 32'(s_data), 32'(prev_data));
            end
            if (prev_ack) check("ack_width", 32'(s_ack), 32'd0);
            check("done_flag", 32'(s_done), 32'(m_done));
            if (fire) begin
                n_assert++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL extra_word: observed %0h expected none", s_data);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("host_word", 32'(s_data), 32'(e));
                    if (e[HW-1]) set_done = 1'b1;
                end
            end
            if (s_ack) ack_seen++;
        end
        prev_valid = s_valid;
        prev_ready = bus.host_ready;
        prev_data  = s_data;
        prev_ack   = s_ack;
        prev_block = !arst || clr;
        if (set_done) m_done = 1'b1;
        if (clr) begin
            exp_q.delete();
            m_done = 1'b0;
            m_cnt  = 0;
        end
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       bus.host_ready = 1'b0;
            1:       bus.host_ready = 1'b1;
            default: bus.host_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_ready(input int mode);
        ready_mode = mode;
        if (mode == 0) bus.host_ready = 1'b0;
        else if (mode == 1) bus.host_ready = 1'b1;
    endtask

    task automatic start_word(input logic [DATA_W-1:0] d);
        bus.intr    = 1'b1;
        bus.data_in = d;
        exp_q.push_back({1'b0, d});
    endtask

    task automatic wait_ack(output int lat);
        int base;
        base = ack_seen;
        lat  = 0;
        while (ack_seen == base && lat < 200) begin
            tick();
            lat++;
        end
        n_assert++;
        assert (ack_seen != base) else begin
            n_fail++;
            $error("FAIL ack_timeout: observed no ack expected ack within 200 cycles");
        end
        if (ack_seen != base) m_cnt++;
    endtask

    task automatic end_word();
        bus.intr = 1'b0;
        tick();
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d);
        int lat;
        start_word(d);
        wait_ack(lat);
        end_word();
    endtask

    task automatic queue_summary(input logic [3:0] sr);
        bus.stop    = 1'b1;
        bus.specreg = sr;
        exp_q.push_back({1'b1, {(DATA_W - 4){1'b0}}, sr});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL drain_timeout: observed %0d words pending expected 0", exp_q.size());
        end
        tick();
        check("valid_fall", 32'(s_valid), 32'd0);
    endtask

    task automatic do_clear();
        bus.stop = 1'b0;
        bus.intr = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        check("clr_word_cnt", 32'(s_word_cnt), 32'd0);
        check("clr_done", 32'(s_done), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int base;
        logic [DATA_W-1:0] d;
        bus.intr       = 1'b0;
        bus.data_in    = '0;
        bus.stop       = 1'b0;
        bus.specreg    = '0;
        bus.host_ready = 1'b1;

        // reset state
        tick();
        tick();
        check("rst_ack", 32'(s_ack), 32'd0);
        check("rst_valid", 32'(s_valid), 32'd0);
        check("rst_data", 32'(s_data), 32'd0);
        check("rst_word_cnt", 32'(s_word_cnt), 32'd0);
        check("rst_stalled", 32'(s_stalled), 32'd0);
        check("rst_done", 32'(s_done), 32'd0);
        arst = 1'b1;
        tick();

        // 1) three pulses, host always ready
        set_ready(1);
        start_word(23'h000001);
        wait_ack(lat);
        check("ack_latency", 32'(lat), 32'd2);
        end_word();
        send_word(23'h000002);
        send_word(23'h7FFFFF);
        check("t1_acks", 32'(ack_seen), 32'd3);
        drain();
        check("t1_word_cnt", 32'(word_cnt), 32'd3);

        // 2) host stalled: 16 words fit, the 17th waits
        set_ready(0);
        tick();
        for (int i = 0; i < 16; i++) begin
            send_word(DATA_W'($urandom()));
        end
        check("t2_acks16", 32'(ack_seen), 32'd19);
        base = ack_seen;
        start_word(DATA_W'($urandom()));
        repeat (4) tick();
        check("t2_stalled", 32'(s_stalled), 32'd1);
        check("t2_no_ack", 32'(ack_seen - base), 32'd0);
        set_ready(1);
        wait_ack(lat);
        end_word();
        check("t2_unstalled", 32'(s_stalled), 32'd0);
        drain();
        check("t2_word_cnt", 32'(word_cnt), 32'(m_cnt));

        // 3) two words then stop with specreg 0101
        do_clear();
        send_word(DATA_W'($urandom()));
        send_word(DATA_W'($urandom()));
        queue_summary(4'b0101);
        drain();
        check("t3_done", 32'(s_done), 32'd1);
        base = ack_seen;
        bus.intr = 1'b1;
        repeat (5) tick();
        bus.intr = 1'b0;
        tick();
        check("t3_end_no_ack", 32'(ack_seen - base), 32'd0);
        check("t3_end_word_cnt", 32'(word_cnt), 32'd2);
        check("t3_end_no_valid", 32'(s_valid), 32'd0);

        // 4) intr held high for 10 cycles
        do_clear();
        base = ack_seen;
        start_word(DATA_W'($urandom()));
        repeat (10) tick();
        bus.intr = 1'b0;
        tick();
        m_cnt++;
        check("t4_one_ack", 32'(ack_seen - base), 32'd1);
        check("t4_word_cnt", 32'(word_cnt), 32'd1);
        drain();

        // 5a) stop and intr rise together: data first
        do_clear();
        d = DATA_W'($urandom());
        start_word(d);
        queue_summary(4'($urandom_range(0, 15)));
        wait_ack(lat);
        end_word();
        drain();
        check("t5_done", 32'(s_done), 32'd1);

        // randomized traffic with a random host
        do_clear();
        set_ready(2);
        for (int i = 0; i < 24; i++) begin
            send_word(DATA_W'($urandom()));
            repeat ($urandom_range(0, 2)) tick();
        end
        queue_summary(4'($urandom_range(0, 15)));
        drain();
        check("rnd_word_cnt", 32'(word_cnt), 32'(m_cnt));
        check("rnd_done", 32'(s_done), 32'd1);

        // 5b) asynchronous reset in the middle of a stream
        do_clear();
        set_ready(0);
        tick();
        for (int i = 0; i < 5; i++) begin
            send_word(DATA_W'($urandom()));
        end
        bus.intr = 1'b0;
        arst = 1'b0;
        exp_q.delete();
        m_done = 1'b0;
        m_cnt  = 0;
        tick();
        check("mid_rst_valid", 32'(s_valid), 32'd0);
        check("mid_rst_data", 32'(s_data), 32'd0);
        check("mid_rst_ack", 32'(s_ack), 32'd0);
        check("mid_rst_word_cnt", 32'(s_word_cnt), 32'd0);
        check("mid_rst_stalled", 32'(s_stalled), 32'd0);
        check("mid_rst_done", 32'(s_done), 32'd0);
        arst = 1'b1;
        set_ready(1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_rst_no_valid", 32'(s_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
